// File: rtl/chacha_pkg.sv
// Shared constants for the ChaCha20 session controller: FSM encoding,
// datapath widths and the TRNG word-count derivation.
package chacha_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ACQ        = 3'd1;
  localparam logic [2:0] ST_GET_DATA   = 3'd2;
  localparam logic [2:0] ST_START_CORE = 3'd3;
  localparam logic [2:0] ST_WAIT_CORE  = 3'd4;
  localparam logic [2:0] ST_OUTPUT     = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;
  localparam logic [2:0] ST_ERR        = 3'd7;

  // Datapath widths; key and nonce share one 352-bit material register
  localparam int KEY_W   = 256;
  localparam int NONCE_W = 96;
  localparam int BLOCK_W = 512;
  localparam int MAT_W   = KEY_W + NONCE_W;

  localparam logic [31:0] COUNTER_INIT_DEFAULT = 32'h0000_0001;

  // Number of TRNG words needed to fill key plus nonce
  function automatic int calc_nwords(input int trng_w);
    return MAT_W / trng_w;
  endfunction

endpackage

// File: rtl/trng_health_mon.sv
// Repetition-count health test on accepted TRNG words. Flags fail in the
// same cycle as the accept that makes the run of identical words reach
// REP_LIMIT, so the controller can abort before using that word.
module trng_health_mon #(
  parameter int W         = 32,
  parameter int REP_LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         accept,
  input  logic [W-1:0] word,
  output logic         fail
);

  localparam int CNT_W = $clog2(REP_LIMIT + 1);

  logic [W-1:0]     prev_q, prev_d;
  logic [CNT_W-1:0] rep_q, rep_d;

  // Next repeat count; a zero count means no previous word in this session
  always_comb begin
    prev_d = prev_q;
    rep_d  = rep_q;
    fail   = 1'b0;
    if (clear) begin
      prev_d = '0;
      rep_d  = '0;
    end else if (accept) begin
      prev_d = word;
      if ((rep_q != '0) && (word == prev_q)) begin
        if (rep_q < CNT_W'(REP_LIMIT)) begin
          rep_d = rep_q + CNT_W'(1);
        end
      end else begin
        rep_d = CNT_W'(1);
      end
      fail = (rep_d == CNT_W'(REP_LIMIT));
    end
  end

  // Previous word and run length registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      rep_q  <= '0;
    end else begin
      prev_q <= prev_d;
      rep_q  <= rep_d;
    end
  end

endmodule

// File: rtl/chacha_session_ctrl.sv
// Session controller for the ChaCha20 keystream path: gathers key and nonce
// from the TRNG with a health check, then pushes a bounded number of blocks
// through the core with an incrementing block counter. Key material is
// zeroised whenever a session ends or aborts.
module chacha_session_ctrl
  import chacha_pkg::*;
#(
  parameter int          TRNG_W       = 32,
  parameter int          MAX_BLOCKS   = 16,
  parameter logic [31:0] COUNTER_INIT = COUNTER_INIT_DEFAULT,
  parameter int          REP_LIMIT    = 3,
  localparam int         BLK_W        = $clog2(MAX_BLOCKS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLK_W-1:0]   num_blocks,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               trng_request,
  input  logic               trng_ready,
  input  logic [TRNG_W-1:0]  trng_data,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [BLOCK_W-1:0] din_state,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [BLOCK_W-1:0] dout_state,
  output logic               core_start,
  input  logic               core_done,
  output logic [KEY_W-1:0]   core_key,
  output logic [NONCE_W-1:0] core_nonce,
  output logic [31:0]        core_counter,
  output logic [BLOCK_W-1:0] core_in_state,
  input  logic [BLOCK_W-1:0] core_out_state
);

  localparam int NWORDS = calc_nwords(TRNG_W);
  localparam int IDX_W  = $clog2(NWORDS + 1);
  localparam int BASE_W = $clog2(MAT_W);

  logic [2:0]         state_q, state_d;
  logic [MAT_W-1:0]   mat_q, mat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        counter_q, counter_d;
  logic [BLK_W-1:0]   rem_q, rem_d;
  logic [BLOCK_W-1:0] din_q, din_d;
  logic [BLOCK_W-1:0] dout_q, dout_d;
  logic               error_q, error_d;
  logic               zdone_q, zdone_d;

  logic               terminal;
  logic               trng_acc;
  logic               health_fail;
  logic               last_acc;
  logic [BASE_W-1:0]  word_base;

  assign terminal  = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
  assign trng_acc  = (state_q == ST_ACQ) && trng_ready;
  assign word_base = BASE_W'(idx_q) * BASE_W'(TRNG_W);

  trng_health_mon #(
    .W         (TRNG_W),
    .REP_LIMIT (REP_LIMIT)
  ) u_health (
    .clk    (clk),
    .rst    (rst),
    .clear  (terminal),
    .accept (trng_acc),
    .word   (trng_data),
    .fail   (health_fail)
  );

  // Session FSM and datapath next-state, with zeroisation on terminal states
  always_comb begin
    state_d   = state_q;
    mat_d     = mat_q;
    idx_d     = idx_q;
    counter_d = counter_q;
    rem_d     = rem_q;
    din_d     = din_q;
    dout_d    = dout_q;
    error_d   = error_q;
    zdone_d   = 1'b0;
    last_acc  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          error_d   = 1'b0;
          counter_d = COUNTER_INIT;
          idx_d     = '0;
          if (num_blocks == '0) begin
            rem_d   = '0;
            zdone_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            rem_d   = (num_blocks > BLK_W'(MAX_BLOCKS)) ? BLK_W'(MAX_BLOCKS) : num_blocks;
            state_d = ST_ACQ;
          end
        end
      end
      ST_ACQ: begin
        if (trng_acc) begin
          mat_d[word_base +: TRNG_W] = trng_data;
          idx_d = idx_q + IDX_W'(1);
          if (health_fail) begin
            state_d = ST_ERR;
          end else if (idx_q == IDX_W'(NWORDS - 1)) begin
            state_d = ST_GET_DATA;
          end
        end
      end
      ST_GET_DATA: begin
        if (din_valid) begin
          din_d   = din_state;
          state_d = ST_START_CORE;
        end
      end
      ST_START_CORE: begin
        state_d = ST_WAIT_CORE;
      end
      ST_WAIT_CORE: begin
        if (core_done) begin
          dout_d  = core_out_state;
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (dout_ready) begin
          rem_d = rem_q - BLK_W'(1);
          if (rem_q == BLK_W'(1)) begin
            last_acc = 1'b1;
            state_d  = ST_DONE;
          end else if (counter_q == 32'hFFFF_FFFF) begin
            state_d = ST_ERR;
          end else begin
            counter_d = counter_q + 32'd1;
            state_d   = ST_GET_DATA;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_d == ST_DONE) || (state_d == ST_ERR)) begin
      mat_d = '0;
    end
    if (state_d == ST_ERR) begin
      dout_d  = '0;
      error_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mat_q     <= '0;
      idx_q     <= '0;
      counter_q <= COUNTER_INIT;
      rem_q     <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      error_q   <= 1'b0;
      zdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mat_q     <= mat_d;
      idx_q     <= idx_d;
      counter_q <= counter_d;
      rem_q     <= rem_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      error_q   <= error_d;
      zdone_q   <= zdone_d;
    end
  end

  assign busy          = !terminal;
  assign done          = last_acc || zdone_q;
  assign error         = error_q;
  assign trng_request  = (state_q == ST_ACQ);
  assign din_ready     = (state_q == ST_GET_DATA);
  assign dout_valid    = (state_q == ST_OUTPUT);
  assign dout_state    = dout_q;
  assign core_start    = (state_q == ST_START_CORE);
  assign core_key      = mat_q[KEY_W-1:0];
  assign core_nonce    = mat_q[MAT_W-1:KEY_W];
  assign core_counter  = counter_q;
  assign core_in_state = din_q;

endmodule

// File: tb/tb_chacha_session_ctrl.sv
// Directed testbench for chacha_session_ctrl. A second instance with the
// block counter starting at all-ones covers counter exhaustion; it shares
// every stimulus input except start.
module tb_chacha_session_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start_x = 1'b0;
  logic [4:0]   num_blocks = '0;
  logic         trng_ready = 1'b0;
  logic [31:0]  trng_data = '0;
  logic         din_valid = 1'b0;
  logic [511:0] din_state = '0;
  logic         dout_ready = 1'b0;
  logic         core_done = 1'b0;
  logic [511:0] core_out_state = '0;

  logic         busy, done, error, trng_request, din_ready, dout_valid, core_start;
  logic [511:0] dout_state, core_in_state;
  logic [255:0] core_key;
  logic [95:0]  core_nonce;
  logic [31:0]  core_counter;

  logic         x_busy, x_done, x_error, x_trng_request, x_din_ready, x_dout_valid, x_core_start;
  logic [511:0] x_dout_state, x_core_in_state;
  logic [255:0] x_core_key;
  logic [95:0]  x_core_nonce;
  logic [31:0]  x_core_counter;

  logic         sel = 1'b0;
  logic         m_done, m_din_ready, m_dout_valid, m_core_start;
  logic [511:0] m_dout_state, m_core_in_state;
  logic [31:0]  m_core_counter;

  logic [31:0]  trng_words [0:10];
  int           total = 0;
  int           bad = 0;
  int           cs_cnt = 0;
  int           cs_x_cnt = 0;

  localparam logic [255:0] EXP_KEY =
    256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [95:0]  EXP_NONCE = 96'h2b2a2928_27262524_23222120;

  always #5 clk = ~clk;

  chacha_session_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
    .busy(busy), .done(done), .error(error),
    .trng_request(trng_request), .trng_ready(trng_ready), .trng_data(trng_data),
    .din_valid(din_valid), .din_ready(din_ready), .din_state(din_state),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_state(dout_state),
    .core_start(core_start), .core_done(core_done), .core_key(core_key),
    .core_nonce(core_nonce), .core_counter(core_counter),
    .core_in_state(core_in_state), .core_out_state(core_out_state)
  );

  chacha_session_ctrl #(.COUNTER_INIT(32'hFFFF_FFFF)) dut_x (
    .clk(clk), .rst(rst), .start(start_x), .num_blocks(num_blocks),
    .busy(x_busy), .done(x_done), .error(x_error),
    .trng_request(x_trng_request), .trng_ready(trng_ready), .trng_data(trng_data),
    .din_valid(din_valid), .din_ready(x_din_ready), .din_state(din_state),
    .dout_valid(x_dout_valid), .dout_ready(dout_ready), .dout_state(x_dout_state),
    .core_start(x_core_start), .core_done(core_done), .core_key(x_core_key),
    .core_nonce(x_core_nonce), .core_counter(x_core_counter),
    .core_in_state(x_core_in_state), .core_out_state(core_out_state)
  );

  assign m_done          = sel ? x_done          : done;
  assign m_din_ready     = sel ? x_din_ready     : din_ready;
  assign m_dout_valid    = sel ? x_dout_valid    : dout_valid;
  assign m_core_start    = sel ? x_core_start    : core_start;
  assign m_dout_state    = sel ? x_dout_state    : dout_state;
  assign m_core_in_state = sel ? x_core_in_state : core_in_state;
  assign m_core_counter  = sel ? x_core_counter  : core_counter;

  // Count core_start pulses of each instance
  always @(posedge clk) begin
    if (core_start) cs_cnt <= cs_cnt + 1;
    if (x_core_start) cs_x_cnt <= cs_x_cnt + 1;
  end

  // Request a session on the selected instance; called at a falling edge
  task automatic begin_session(input logic which, input logic [4:0] nb);
    if (which) start_x = 1'b1; else start = 1'b1;
    num_blocks = nb;
    @(negedge clk);
    start = 1'b0;
    start_x = 1'b0;
  endtask

  // Offer n TRNG words on consecutive cycles
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      trng_ready = 1'b1;
      trng_data  = trng_words[i];
      @(negedge clk);
    end
    trng_ready = 1'b0;
    trng_data  = '0;
  endtask

  task automatic load_seq_words();
    for (int i = 0; i < 11; i++) trng_words[i] = 32'h03020100 + 32'h04040404 * i;
  endtask

  // Run one block handshake on the selected instance and record observations
  task automatic drive_block(input logic [511:0] din_v, input logic [511:0] res_v, input int stall,
                             output bit ok, output logic [31:0] ctr, output logic [511:0] in_seen,
                             output logic [511:0] out_seen, output bit stable, output bit done_seen);
    int g;
    ok = 1; stable = 1; done_seen = 0; ctr = '0; in_seen = '0; out_seen = '0;
    g = 0;
    while (!m_din_ready && g < 50) begin @(negedge clk); g++; end
    if (!m_din_ready) begin ok = 0; return; end
    din_valid = 1'b1; din_state = din_v;
    @(negedge clk);
    din_valid = 1'b0;
    g = 0;
    while (!m_core_start && g < 10) begin @(negedge clk); g++; end
    if (!m_core_start) begin ok = 0; return; end
    ctr = m_core_counter; in_seen = m_core_in_state;
    @(negedge clk);
    @(negedge clk);
    if (m_core_counter !== ctr || m_core_in_state !== in_seen) stable = 0;
    core_done = 1'b1; core_out_state = res_v;
    @(negedge clk);
    core_done = 1'b0;
    g = 0;
    while (!m_dout_valid && g < 10) begin @(negedge clk); g++; end
    if (!m_dout_valid) begin ok = 0; return; end
    out_seen = m_dout_state;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!m_dout_valid || m_dout_state !== out_seen) stable = 0;
    end
    dout_ready = 1'b1;
    #1 done_seen = m_done;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    total++;
    if ({busy, done, error, trng_request, din_ready, dout_valid, core_start} !== 7'b0) begin
      bad++; $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
                      {busy, done, error, trng_request, din_ready, dout_valid, core_start});
    end
    total++;
    if (core_key !== '0 || core_nonce !== '0 || dout_state !== '0 || core_in_state !== '0) begin
      bad++; $display("[TB] FAIL reset_data: key %h nonce %h expected all zero", core_key, core_nonce);
    end
    total++;
    if (core_counter !== 32'h1) begin
      bad++; $display("[TB] FAIL reset_counter: got %h expected 00000001", core_counter);
    end
    total++;
    if (x_core_counter !== 32'hFFFF_FFFF) begin
      bad++; $display("[TB] FAIL reset_counter_x: got %h expected ffffffff", x_core_counter);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    bit ok, stable, dn; logic [31:0] ctr; logic [511:0] ins, outs; int cs0;
    sel = 1'b0; load_seq_words(); cs0 = cs_cnt;
    begin_session(1'b0, 5'd1);
    total++;
    if (trng_request !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL single_acq: req %b busy %b expected 1 1", trng_request, busy);
    end
    feed(11);
    total++;
    if (trng_request !== 1'b0 || din_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL single_get: req %b din_ready %b expected 0 1", trng_request, din_ready);
    end
    total++;
    if (core_key !== EXP_KEY) begin
      bad++; $display("[TB] FAIL single_key: got %h expected %h", core_key, EXP_KEY);
    end
    total++;
    if (core_nonce !== EXP_NONCE) begin
      bad++; $display("[TB] FAIL single_nonce: got %h expected %h", core_nonce, EXP_NONCE);
    end
    drive_block({16{32'h1111_2222}}, {16{32'hCAFE_0001}}, 0, ok, ctr, ins, outs, stable, dn);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL single_timeout: got 0 expected 1"); end
    total++;
    if (ctr !== 32'h1 || ins !== {16{32'h1111_2222}}) begin
      bad++; $display("[TB] FAIL single_core_in: counter %h expected 00000001", ctr);
    end
    total++;
    if (outs !== {16{32'hCAFE_0001}} || dn !== 1'b1) begin
      bad++; $display("[TB] FAIL single_out: done %b expected 1, dout %h", dn, outs);
    end
    total++;
    if (cs_cnt - cs0 !== 1) begin
      bad++; $display("[TB] FAIL single_starts: got %0d expected 1", cs_cnt - cs0);
    end
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b0 || core_key !== '0 || core_nonce !== '0) begin
      bad++; $display("[TB] FAIL single_end: done %b busy %b error %b expected 0 0 0 and zero key",
                      done, busy, error);
    end
  endtask

  task automatic test_multi_block();
    bit ok, stable, dn; logic [31:0] ctr; logic [511:0] ins, outs; int cs0;
    sel = 1'b0; load_seq_words(); cs0 = cs_cnt;
    begin_session(1'b0, 5'd3);
    feed(11);
    start = 1'b1; num_blocks = 5'd0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || din_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("[TB] FAIL busy_start_ignored: busy %b din_ready %b done %b expected 1 1 0",
                      busy, din_ready, done);
    end
    for (int b = 0; b < 3; b++) begin
      drive_block({16{32'hB000_0000 + b}}, {16{32'hD000_0000 + b}}, (b == 1) ? 5 : 0,
                  ok, ctr, ins, outs, stable, dn);
      total++;
      if (!ok || ctr !== 32'(b + 1)) begin
        bad++; $display("[TB] FAIL multi_counter: block %0d got %h expected %h", b, ctr, 32'(b + 1));
      end
      total++;
      if (!stable || outs !== {16{32'hD000_0000 + b}}) begin
        bad++; $display("[TB] FAIL multi_stable: block %0d stable %b expected 1", b, stable);
      end
      total++;
      if (dn !== (b == 2)) begin
        bad++; $display("[TB] FAIL multi_done: block %0d got %b expected %b", b, dn, (b == 2));
      end
    end
    total++;
    if (cs_cnt - cs0 !== 3) begin
      bad++; $display("[TB] FAIL multi_starts: got %0d expected 3", cs_cnt - cs0);
    end
  endtask

  task automatic test_health_error();
    int cs0;
    sel = 1'b0; load_seq_words(); cs0 = cs_cnt;
    trng_words[4] = 32'hDEAD_BEEF; trng_words[5] = 32'hDEAD_BEEF; trng_words[6] = 32'hDEAD_BEEF;
    begin_session(1'b0, 5'd1);
    feed(7);
    total++;
    if (error !== 1'b1 || busy !== 1'b0 || trng_request !== 1'b0) begin
      bad++; $display("[TB] FAIL health_err: error %b busy %b req %b expected 1 0 0",
                      error, busy, trng_request);
    end
    total++;
    if (core_key !== '0 || core_nonce !== '0) begin
      bad++; $display("[TB] FAIL health_zero: key %h nonce %h expected zero", core_key, core_nonce);
    end
    feed(4);
    @(negedge clk);
    total++;
    if (cs_cnt - cs0 !== 0 || error !== 1'b1) begin
      bad++; $display("[TB] FAIL health_no_core: starts %0d error %b expected 0 1", cs_cnt - cs0, error);
    end
    begin_session(1'b0, 5'd0);
    total++;
    if (error !== 1'b0 || done !== 1'b1) begin
      bad++; $display("[TB] FAIL health_clear: error %b done %b expected 0 1", error, done);
    end
  endtask

  task automatic test_counter_exhaust();
    bit ok, stable, dn; logic [31:0] ctr; logic [511:0] ins, outs; int cs0;
    sel = 1'b1; load_seq_words(); cs0 = cs_x_cnt;
    begin_session(1'b1, 5'd2);
    feed(11);
    drive_block({16{32'h5555_0000}}, {16{32'h7777_0000}}, 0, ok, ctr, ins, outs, stable, dn);
    total++;
    if (!ok || ctr !== 32'hFFFF_FFFF || dn !== 1'b0) begin
      bad++; $display("[TB] FAIL exhaust_block: counter %h done %b expected ffffffff 0", ctr, dn);
    end
    total++;
    if (x_error !== 1'b1 || x_busy !== 1'b0 || x_dout_state !== '0 || x_core_key !== '0) begin
      bad++; $display("[TB] FAIL exhaust_err: error %b busy %b expected 1 0 with zeroised data",
                      x_error, x_busy);
    end
    repeat (3) @(negedge clk);
    total++;
    if (cs_x_cnt - cs0 !== 1 || x_din_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL exhaust_starts: got %0d expected 1", cs_x_cnt - cs0);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_block();
    bit ok, stable, dn; logic [31:0] ctr; logic [511:0] ins, outs;
    sel = 1'b0; load_seq_words();
    begin_session(1'b0, 5'd1);
    feed(11);
    din_valid = 1'b1; din_state = {16{32'h9999_0000}};
    @(negedge clk);
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, error, trng_request, din_ready, dout_valid, core_start} !== 7'b0) begin
      bad++; $display("[TB] FAIL midrst_ctrl: got %b expected 0000000",
                      {busy, done, error, trng_request, din_ready, dout_valid, core_start});
    end
    total++;
    if (core_key !== '0 || core_nonce !== '0 || core_in_state !== '0 || core_counter !== 32'h1) begin
      bad++; $display("[TB] FAIL midrst_data: counter %h expected 00000001 and zero material", core_counter);
    end
    core_done = 1'b1; core_out_state = {16{32'hEEEE_0000}};
    @(negedge clk);
    core_done = 1'b0; rst = 1'b0;
    @(negedge clk);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    total++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || dout_state !== '0) begin
      bad++; $display("[TB] FAIL midrst_late_done: dout_valid %b busy %b expected 0 0", dout_valid, busy);
    end
    begin_session(1'b0, 5'd1);
    feed(11);
    drive_block({16{32'h1234_5678}}, {16{32'h8765_4321}}, 0, ok, ctr, ins, outs, stable, dn);
    total++;
    if (!ok || ctr !== 32'h1 || dn !== 1'b1 || outs !== {16{32'h8765_4321}}) begin
      bad++; $display("[TB] FAIL midrst_fresh: counter %h done %b expected 00000001 1", ctr, dn);
    end
  endtask

  task automatic test_zero_blocks();
    start = 1'b1; num_blocks = 5'd0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy0: got %b expected 0", busy); end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || trng_request !== 1'b0) begin
      bad++; $display("[TB] FAIL zero_done: done %b busy %b req %b expected 1 0 0", done, busy, trng_request);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL zero_pulse: done %b busy %b expected 0 0", done, busy);
    end
  endtask

  task automatic test_clamp();
    bit ok, stable, dn; logic [31:0] ctr; logic [511:0] ins, outs;
    sel = 1'b0; load_seq_words();
    begin_session(1'b0, 5'd20);
    feed(11);
    for (int b = 0; b < 16; b++) begin
      drive_block({16{32'hC000_0000 + b}}, {16{32'hF000_0000 + b}}, 0, ok, ctr, ins, outs, stable, dn);
      total++;
      if (!ok || ctr !== 32'(b + 1) || dn !== (b == 15)) begin
        bad++; $display("[TB] FAIL clamp_block: block %0d counter %h done %b expected %h %b",
                        b, ctr, dn, 32'(b + 1), (b == 15));
      end
    end
    total++;
    if (busy !== 1'b0 || din_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL clamp_end: busy %b din_ready %b expected 0 0", busy, din_ready);
    end
  endtask

  // Watchdog so a stuck handshake still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    test_reset();
    test_single_block();
    test_multi_block();
    test_health_error();
    test_counter_exhaust();
    test_reset_mid_block();
    test_zero_blocks();
    test_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chacha_session_ctrl.md
Name: chacha_session_ctrl

Overview:
- Session controller for the ChaCha20 keystream path, sitting between the TRNG, the ChaCha20 core and the host data interface.
- On start it collects fresh key and nonce material from the TRNG and health-checks each word.
- It then runs a parametrised, run-time-selectable number of 512-bit blocks through the core, incrementing the block counter per block.
- Key and nonce registers are zeroised at session end or on error.

Parameters:
- TRNG_W, 32, TRNG word width; legal values 8, 16, 32. NWORDS = 352/TRNG_W.
- MAX_BLOCKS, 16, upper bound on blocks per session; BLK_W = clog2(MAX_BLOCKS+1).
- COUNTER_INIT, 32'h00000001, block counter value for the first block.
- REP_LIMIT, 3, number of consecutive identical TRNG words that triggers a health error (≥2).

Ports:
- clk  in  1  sole clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  session request; sampled only in IDLE, DONE or ERR.
- num_blocks  in  BLK_W  block count; captured on start.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- done  out  1  one-cycle pulse when the last block is accepted on dout.
- error  out  1  sticky health/counter error; cleared by the next accepted start.
- trng_request  out  1  level; high in ACQ.
- trng_ready  in  1  TRNG word valid.
- trng_data  in  TRNG_W  random word.
- din_valid  in  1  input block valid.
- din_ready  out  1  input block ready.
- din_state  in  512  input block.
- dout_valid  out  1  output block valid.
- dout_ready  in  1  output block ready.
- dout_state  out  512  output block.
- core_start  out  1  one-cycle start pulse to the ChaCha20 core.
- core_done  in  1  core completion pulse.
- core_key  out  256  key to core.
- core_nonce  out  96  nonce to core.
- core_counter  out  32  block counter to core.
- core_in_state  out  512  registered input block to core.
- core_out_state  in  512  core result.

Behaviour:
- Reset values:
  - All outputs 0; key, nonce and data registers 0.
  - Counter = COUNTER_INIT.
  - State IDLE.
- States: IDLE, ACQ, GET_DATA, START_CORE, WAIT_CORE, OUTPUT, DONE, ERR.
- Start handling (in IDLE, DONE or ERR, start=1):
  - Clear error and capture num_blocks.
  - Load counter = COUNTER_INIT and clear the word index and repeat counter.
  - num_blocks=0 → DONE directly, with a done pulse the next cycle.
  - num_blocks>MAX_BLOCKS → clamp to MAX_BLOCKS.
  - Otherwise → ACQ.
  - start while busy is ignored.
- ACQ (TRNG word collection):
  - trng_request=1. A word is accepted in any cycle with trng_request && trng_ready.
  - Word i (0-based) fills bits [i*TRNG_W +: TRNG_W] of the 352-bit register {nonce, key}: key occupies bits 255:0, nonce bits 351:256.
  - After NWORDS accepts → GET_DATA, with trng_request low in the following cycle.
- Health check:
  - The repeat counter increments when an accepted word equals the previous accepted word, and resets to 1 otherwise.
  - When it reaches REP_LIMIT → ERR.
- GET_DATA: din_ready=1. On din_valid, register din_state → START_CORE.
- START_CORE: core_start=1 for exactly one cycle → WAIT_CORE.
- WAIT_CORE:
  - On core_done, register core_out_state into dout_state → OUTPUT.
  - core_key, core_nonce, core_counter and core_in_state are held stable from START_CORE until core_done.
- OUTPUT: dout_valid=1 and dout_state is held until dout_ready (AXI-style; no combinational ready→valid path). On acceptance:
  - Decrement the remaining-block count.
  - If remaining=0 → DONE, done=1 in the transition cycle.
  - Else if counter==32'hFFFFFFFF → ERR (counter exhaustion; no wrap).
  - Else counter+1 → GET_DATA.
- DONE and ERR:
  - Key and nonce are zeroised on entry.
  - ERR additionally zeroises dout_state and sets error=1.
- Latency: per block, 1 cycle from din accept to core_start, then core latency, then dout_valid the cycle after core_done.
- Simultaneous events: core_done outside WAIT_CORE is ignored; trng_ready outside ACQ is ignored.
- Reset mid-operation returns to the reset state immediately, with no done pulse and all material cleared.

Decomposition:
- Shared package chacha_pkg holds:
  - State encoding localparams.
  - KEY_W=256, NONCE_W=96, BLOCK_W=512 and the NWORDS derivation.
  - COUNTER_INIT default.
- Sub-module trng_health_mon (repetition-count test; inputs word and accept, outputs fail) is separated so it can be reused for an adaptive-proportion test later.

Test Plan:
- TRNG_W=32, num_blocks=1, TRNG words 0x03020100, 0x07060504 … (11 distinct) → core_key = 256'h1f1e1d1c_…_03020100 and core_nonce from words 8–10; core_counter=1; one core_start; done pulse after dout accept; error=0.
- num_blocks=3 with dout_ready stalled for 5 cycles on block 2 → core_counter 1, 2, 3 in order; dout_state stable during the stall; exactly 3 core_start pulses.
- TRNG delivers 0xDEADBEEF three times consecutively at words 4–6 → ERR after the third accept; error=1; key and nonce zero; no core_start; next start clears error.
- COUNTER_INIT=32'hFFFFFFFF, num_blocks=2 → block 1 output with counter 0xFFFFFFFF, then ERR with no second core_start.
- rst asserted during WAIT_CORE → all outputs 0 in the same cycle; late core_done ignored; a fresh session then completes normally.
- num_blocks=0 → no trng_request; done pulse the cycle after start; busy never asserted.
